// File: rtl/plus_1_step_counter.sv
// rtl/plus_1_step_counter.sv - run-length sequencer wrapped around an external plus_1_adder.
// Build option: define PLUS_1_SAT_EN to saturate at MAX_INT instead of wrapping to MIN_INT.
module plus_1_step_counter #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              start,
  input  logic [STEP_W-1:0] steps,
  output logic [WIDTH-1:0]  adder_in,
  input  logic [WIDTH-1:0]  adder_out,
  output logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_INT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  // The adder cannot produce MAX_INT+1, so the post-MAX_INT value is generated here.
`ifdef PLUS_1_SAT_EN
  localparam logic [WIDTH-1:0] AFTER_MAX = MAX_INT;
`else
  localparam logic [WIDTH-1:0] AFTER_MAX = MIN_INT;
`endif

  state_t              state, state_next;
  logic [WIDTH-1:0]    value_next;
  logic                ovf_next;
  logic [STEP_W-1:0]   remaining, remaining_next;

  assign adder_in = value;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      value     <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      value     <= value_next;
      ovf       <= ovf_next;
      remaining <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state;
    value_next     = value;
    ovf_next       = ovf;
    remaining_next = remaining;
    unique case (state)
      IDLE: begin
        if (load) begin
          value_next = load_val;
          ovf_next   = 1'b0;
        end else if (start) begin
          if (steps == '0) begin
            state_next = DONE;
          end else begin
            remaining_next = steps;
            state_next     = RUN;
          end
        end
      end
      RUN: begin
        if (value == MAX_INT) begin
          value_next = AFTER_MAX;
          ovf_next   = 1'b1;
        end else begin
          value_next = adder_out;
        end
        remaining_next = remaining - STEP_W'(1);
        if (remaining == STEP_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
